// File: rtl/wb_stage_regfile_if.sv
// Writeback-stage bus: MEM/WB inputs, decode read ports and retire counter.
// The master drives the pipeline side; the slave is the writeback stage itself.
interface wb_stage_regfile_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic             valid_w;
  logic             reg_write_w;
  logic [1:0]       result_src_w;
  logic [XLEN-1:0]  alu_result_w;
  logic [XLEN-1:0]  read_data_w;
  logic [XLEN-1:0]  pc_plus4_w;
  logic [XLEN-1:0]  ext_imm_w;
  logic [4:0]       rd_w;
  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [XLEN-1:0]  rd1_d;
  logic [XLEN-1:0]  rd2_d;
  logic [XLEN-1:0]  result_w;
  logic             wr_en_w;
  logic             cnt_clr;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output valid_w, reg_write_w, result_src_w, alu_result_w, read_data_w,
           pc_plus4_w, ext_imm_w, rd_w, rs1_d, rs2_d, cnt_clr,
    input  rd1_d, rd2_d, result_w, wr_en_w, retired_cnt
  );

  modport slave (
    input  valid_w, reg_write_w, result_src_w, alu_result_w, read_data_w,
           pc_plus4_w, ext_imm_w, rd_w, rs1_d, rs2_d, cnt_clr,
    output rd1_d, rd2_d, result_w, wr_en_w, retired_cnt
  );
endinterface

// File: rtl/wb_stage_regfile.sv
// Writeback stage: result select, 32x32 register file (x0 = 0), 64-bit retire counter.
// Macro WB_BYPASS_EN: forwards the same-cycle WB write onto the decode read ports.
module wb_stage_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input logic              clk,
  input logic              rst,
  wb_stage_regfile_if.slave wb
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [XLEN-1:0]  result;
  logic             wr_en;
  logic [XLEN-1:0]  rd1;
  logic [XLEN-1:0]  rd2;

  always_comb begin
    result = wb.alu_result_w;
    case (wb.result_src_w)
      2'b00: result = wb.alu_result_w;
      2'b01: result = wb.read_data_w;
      2'b10: result = wb.pc_plus4_w;
      2'b11: result = wb.ext_imm_w;
    endcase
  end

  // Bubbles and x0 destinations never reach the array.
  assign wr_en = wb.valid_w & wb.reg_write_w & (wb.rd_w != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wb.rd_w] <= result;
    end
  end

  always_comb begin
    rd1 = (wb.rs1_d == 5'd0) ? '0 : regs_q[wb.rs1_d];
    rd2 = (wb.rs2_d == 5'd0) ? '0 : regs_q[wb.rs2_d];
`ifdef WB_BYPASS_EN
    // wr_en implies rd_w != 0, so a match can never override the x0 rule.
    if (wr_en && (wb.rs1_d == wb.rd_w)) rd1 = result;
    if (wr_en && (wb.rs2_d == wb.rd_w)) rd2 = result;
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wb.cnt_clr) begin
      cnt_d = '0;
    end else if (wb.valid_w) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wb.result_w    = result;
  assign wb.wr_en_w     = wr_en;
  assign wb.rd1_d       = rd1;
  assign wb.rd2_d       = rd2;
  assign wb.retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed vector bench for wb_stage_regfile; expectations follow WB_BYPASS_EN when defined.
module tb_wb_stage_regfile;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_stage_regfile_if #(.XLEN(32), .CNT_W(64)) bus ();

  wb_stage_regfile #(.XLEN(32), .NREGS(32), .CNT_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic        vld;
    logic        we;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        clr;
    logic [31:0] e_res;
    logic        e_wen;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(logic r, logic v, logic w, logic [1:0] s,
                              logic [31:0] a, logic [31:0] l, logic [31:0] p, logic [31:0] im,
                              logic [4:0] d, logic [4:0] s1, logic [4:0] s2, logic c,
                              logic [31:0] er, logic ew, logic [31:0] e1, logic [31:0] e2,
                              logic [63:0] ec);
    vec_t t;
    t.rst = r; t.vld = v; t.we = w; t.src = s;
    t.alu = a; t.ld = l; t.pc4 = p; t.imm = im;
    t.rd = d; t.rs1 = s1; t.rs2 = s2; t.clr = c;
    t.e_res = er; t.e_wen = ew; t.e_rd1 = e1; t.e_rd2 = e2; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    rst                = t.rst;
    bus.valid_w        = t.vld;
    bus.reg_write_w    = t.we;
    bus.result_src_w   = t.src;
    bus.alu_result_w   = t.alu;
    bus.read_data_w    = t.ld;
    bus.pc_plus4_w     = t.pc4;
    bus.ext_imm_w      = t.imm;
    bus.rd_w           = t.rd;
    bus.rs1_d          = t.rs1;
    bus.rs2_d          = t.rs2;
    bus.cnt_clr        = t.clr;
  endtask

  function automatic logic [31:0] pat(int r);
    return (32'(r) * 32'h0101_0101) ^ 32'h0000_005A;
  endfunction

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;

    // Fields: rst vld we src alu ld pc4 imm rd rs1 rs2 clr | res wen rd1 rd2 cnt
    vecs[0]  = mk(1,1,1,0, 32'hDEAD_BEEF,0,0,0, 5,5,0,0, 32'hDEAD_BEEF,1, BYP ? 32'hDEAD_BEEF : 32'h0,0, 0);
    vecs[1]  = mk(1,0,0,0, 0,0,0,0, 0,5,5,0, 0,0, 32'hDEAD_BEEF,32'hDEAD_BEEF, 1);
    vecs[2]  = mk(0,1,1,0, 32'h77,0,0,0, 6,5,0,0, 32'h77,1, 32'hDEAD_BEEF,0, 1);
    vecs[3]  = mk(1,0,0,0, 0,0,0,0, 0,5,6,0, 0,0, 0,0, 0);
    vecs[4]  = mk(1,0,0,0, 32'h11,32'h22,32'h33,32'h44, 0,0,0,0, 32'h11,0, 0,0, 0);
    vecs[5]  = mk(1,0,0,1, 32'h11,32'h22,32'h33,32'h44, 0,0,0,0, 32'h22,0, 0,0, 0);
    vecs[6]  = mk(1,0,0,2, 32'h11,32'h22,32'h33,32'h44, 0,0,0,0, 32'h33,0, 0,0, 0);
    vecs[7]  = mk(1,0,0,3, 32'h11,32'h22,32'h33,32'h44, 0,0,0,0, 32'h44,0, 0,0, 0);
    vecs[8]  = mk(1,1,1,0, 32'hFFFF_FFFF,0,0,0, 0,0,0,0, 32'hFFFF_FFFF,0, 0,0, 0);
    vecs[9]  = mk(1,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 1);
    vecs[10] = mk(1,1,1,0, 32'hAA,0,0,0, 7,0,0,0, 32'hAA,1, 0,0, 1);
    vecs[11] = mk(1,0,1,0, 32'h55,0,0,0, 7,7,0,0, 32'h55,0, 32'hAA,0, 2);
    vecs[12] = mk(1,0,0,0, 0,0,0,0, 0,7,7,0, 0,0, 32'hAA,32'hAA, 2);
    vecs[13] = mk(1,1,1,0, 32'h1234,0,0,0, 9,9,7,0, 32'h1234,1, BYP ? 32'h1234 : 32'h0,32'hAA, 2);
    vecs[14] = mk(1,0,0,0, 0,0,0,0, 0,9,0,0, 0,0, 32'h1234,0, 3);
    vecs[15] = mk(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 3);
    vecs[16] = mk(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 4);
    vecs[17] = mk(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 5);
    vecs[18] = mk(1,1,0,0, 0,0,0,0, 0,0,0,1, 0,0, 0,0, 6);
    vecs[19] = mk(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0);
    vecs[20] = mk(1,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 1);
    vecs[21] = mk(1,1,1,2, 0,0,32'h100,0, 3,9,3,0, 32'h100,1, 32'h1234, BYP ? 32'h100 : 32'h0, 1);
    vecs[22] = mk(1,0,0,0, 0,0,0,0, 0,3,3,0, 0,0, 32'h100,32'h100, 2);

    idle = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0);
    drive(idle);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 23; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d result_w", i), 64'(bus.result_w), 64'(vecs[i].e_res));
      chk($sformatf("v%0d wr_en_w", i), 64'(bus.wr_en_w), 64'(vecs[i].e_wen));
      chk($sformatf("v%0d rd1_d", i), 64'(bus.rd1_d), 64'(vecs[i].e_rd1));
      chk($sformatf("v%0d rd2_d", i), 64'(bus.rd2_d), 64'(vecs[i].e_rd2));
      chk($sformatf("v%0d retired_cnt", i), bus.retired_cnt, vecs[i].e_cnt);
    end

    // Fill x1..x31 with distinct patterns, then read every register back.
    idle.rst = 1'b1;
    for (int r = 1; r < 32; r++) begin
      @(posedge clk);
      #1;
      drive(idle);
      bus.valid_w      = 1'b1;
      bus.reg_write_w  = 1'b1;
      bus.rd_w         = 5'(r);
      bus.alu_result_w = pat(r);
    end
    for (int r = 0; r < 32; r++) begin
      @(posedge clk);
      #1;
      drive(idle);
      bus.rs1_d = 5'(r);
      bus.rs2_d = 5'(31 - r);
      @(negedge clk);
      chk($sformatf("fill rd1 x%0d", r), 64'(bus.rd1_d), 64'((r == 0) ? 32'h0 : pat(r)));
      chk($sformatf("fill rd2 x%0d", 31 - r), 64'(bus.rd2_d), 64'((r == 31) ? 32'h0 : pat(31 - r)));
    end
    chk("fill retired_cnt", bus.retired_cnt, 64'd33);

    // Reset overrides a simultaneous clear-free retire.
    @(posedge clk);
    #1;
    drive(idle);
    rst = 1'b0;
    bus.valid_w = 1'b1;
    @(posedge clk);
    #1;
    drive(idle);
    bus.rs1_d = 5'd31;
    @(negedge clk);
    chk("post-reset retired_cnt", bus.retired_cnt, 64'd0);
    chk("post-reset rd1 x31", 64'(bus.rd1_d), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
